// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the switch input debouncer.
// Holds the per-channel state encoding, the channel count and the default
// debounce length (10 ms at 100 MHz).
package input_debouncer_pkg;

    localparam int unsigned NUM_CH              = 3;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

    // S_* are settled levels, W_* are waiting to confirm a change.
    typedef enum logic [1:0] {
        S_LO = 2'd0,
        W_HI = 2'd1,
        S_HI = 2'd2,
        W_LO = 2'd3
    } deb_state_e;

endpackage

// File: rtl/input_debouncer_if.sv
// Raw switch levels in, debounced levels and edge pulses out.
//   left/right/haz          : raw asynchronous switch levels
//   left_db/right_db/haz_db : debounced levels
//   rise/fall               : one-cycle edge pulses, bit0 left, bit1 right, bit2 haz
// master = switch side / consumer, slave = debouncer.
interface input_debouncer_if;
    import input_debouncer_pkg::*;

    logic              left;
    logic              right;
    logic              haz;
    logic              left_db;
    logic              right_db;
    logic              haz_db;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;

    modport master (
        output left, right, haz,
        input  left_db, right_db, haz_db, rise, fall
    );

    modport slave (
        input  left, right, haz,
        output left_db, right_db, haz_db, rise, fall
    );

endinterface

// File: rtl/input_debouncer_debounce_ch.sv
// One debounced channel: 2-flop synchroniser, confirm counter and level FSM.
//   clk, reset (async, active low)
//   raw  : asynchronous input level
//   db   : debounced level
//   rise : one-cycle pulse on db 0->1
//   fall : one-cycle pulse on db 1->0
module debounce_ch
    import input_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1;
    logic             s2;
    deb_state_e       state;
    deb_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             db_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    // Metastability synchroniser; only s2 feeds the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_LO;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            db    <= db_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // Any disagreeing sample while waiting drops back to the settled state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        db_nxt    = db;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            S_LO: begin
                if (s2) begin
                    state_nxt = W_HI;
                    cnt_nxt   = CNT_ONE;
                end
            end
            W_HI: begin
                if (!s2) begin
                    state_nxt = S_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = S_HI;
                    cnt_nxt   = '0;
                    db_nxt    = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_HI: begin
                if (!s2) begin
                    state_nxt = W_LO;
                    cnt_nxt   = CNT_ONE;
                end
            end
            W_LO: begin
                if (s2) begin
                    state_nxt = S_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = S_LO;
                    cnt_nxt   = '0;
                    db_nxt    = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_LO;
                cnt_nxt   = '0;
                db_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/input_debouncer.sv
// Debounces the left, right and hazard switches for the tail-light controller.
//   clk, reset (async, active low)
//   bus : input_debouncer_if.slave (raw levels in, debounced levels and pulses out)
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input_debouncer_if.slave     bus
);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;

    assign raw = {bus.haz, bus.right, bus.left};

    // Channels are independent; no arbitration between switches here.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[i]),
            .db   (db[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign bus.left_db  = db[0];
    assign bus.right_db = db[1];
    assign bus.haz_db   = db[2];
    assign bus.rise     = rise;
    assign bus.fall     = fall;

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Input-conditioning stage that sits directly upstream of tail_lights_control in the Thunderbird tail-light design.
- Takes the raw asynchronous slide-switch/button levels left, right and haz.
- Synchronises each one into the clk domain and debounces it with a per-channel counter.
- Outputs stable levels plus one-cycle rise and fall pulses; the top level wires the stable levels in place of the raw switches.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive synchronised samples (after the first) that must agree before a level change is accepted (10 ms at 100 MHz); legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; localparam, not overridable.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- left  input  1  raw left-turn switch, asynchronous
- right  input  1  raw right-turn switch, asynchronous
- haz  input  1  raw hazard switch, asynchronous
- left_db  output  1  debounced left level
- right_db  output  1  debounced right level
- haz_db  output  1  debounced haz level
- rise  output  3  one-cycle pulse on debounced 0->1; bit0 left, bit1 right, bit2 haz
- fall  output  3  one-cycle pulse on debounced 1->0; same bit order

Behaviour:
- Reset (reset==0, asynchronous): all sync flops 0, every channel in S_LO, counters 0, *_db=0, rise=0, fall=0. No pulses are generated by reset entry or release.
- Synchroniser: 2 flops per channel, s1<=raw, s2<=s1. The FSM reads only s2.
- Per-channel FSM, 4 states, all outputs registered:
  - S_LO (db=0): if s2==1, go to W_HI with cnt<=1; else stay.
  - W_HI (db=0): if s2==0, go to S_LO with cnt<=0 (glitch rejected, no pulse). Else if cnt==DEBOUNCE_CYCLES, go to S_HI with db<=1 and rise<=1. Else cnt<=cnt+1.
  - S_HI (db=1): if s2==0, go to W_LO with cnt<=1; else stay.
  - W_LO (db=1): mirror of W_HI. s2==1 returns to S_HI; cnt==DEBOUNCE_CYCLES goes to S_LO with db<=0 and fall<=1.
- Pulses: rise and fall are high for exactly one clk, in the same cycle db first shows its new value. They are cleared the following cycle.
- Latency: raw input stable from just before edge k gives db changed after edge k+DEBOUNCE_CYCLES+2.
- Glitch threshold: a raw excursion of <= DEBOUNCE_CYCLES clocks never changes db. An excursion of >= DEBOUNCE_CYCLES+1 clocks always does.
- Counter never wraps; maximum value is DEBOUNCE_CYCLES.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses. The block does no left/right/haz arbitration; that stays in tail_lights_control.
- Reset mid-debounce: the channel returns to S_LO/db=0 immediately. A raw level held high through reset release re-debounces from scratch, and db rises DEBOUNCE_CYCLES+2 edges after the first edge following release, with a rise pulse.
- Bouncing in W_* resets progress fully: any disagreeing sample returns the channel to its stable state, so there is no partial credit.

Decomposition:
- Shared package/header: state encodings S_LO, W_HI, S_HI, W_LO (2-bit) and the default DEBOUNCE_CYCLES constant, so the timers and the test bench use the same value.
- One sub-module: debounce_ch. It holds the synchroniser, FSM, counter, db, rise and fall for one bit, parameterised by DEBOUNCE_CYCLES.
- input_debouncer instantiates debounce_ch three times and packs rise and fall.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset check: hold reset=0 with left=right=haz=1 -> all outputs 0. Release reset at edge 0 -> left_db/right_db/haz_db=1 after edge 6, rise=3'b111 for exactly that one cycle, then 0.
- Clean press: left 0->1 before edge 10 -> left_db=1 after edge 16, rise[0] pulses once. Release left before edge 30 -> left_db=0 after edge 36, fall[0] pulses once.
- Glitch rejection: haz high for exactly 4 clocks -> haz_db stays 0, no rise/fall. Haz high for 5 clocks -> haz_db goes 1 for 5 clocks then 0 (i.e. it returns low 5 clocks later), with one rise pulse and one fall pulse.
- Bounce: right toggles 1,0,1,0,1 each clock, then stays 1 -> right_db rises 6 edges after the final 0->1 edge, single rise[1] pulse.
- Reset mid-operation: left held 1, assert reset while the channel is in W_HI (cnt=2) -> left_db stays 0, no pulse. Release reset -> full 6-edge latency before left_db=1.
- Independence: left and haz change at the same edge -> rise[0] and rise[2] pulse in the same cycle, right_db unchanged.
